// File: rtl/clock_adjust_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_adjust_ctrl_if
// Brief    : Front-panel button inputs and per-field adjust outputs of the
//            clock adjust controller, bundled as one port.
// Revision : 1.0 - initial release
// ============================================================================
interface clock_adjust_ctrl_if;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [5:0] adj_en;
  logic       adj_up;
  logic       adj_down;
  logic [2:0] mode;

  // Controller side: consumes raw buttons, drives the field counters
  modport master (
    input  btn_mode, btn_up, btn_down,
    output adj_en, adj_up, adj_down, mode
  );

  // Panel / counter side
  modport slave (
    output btn_mode, btn_up, btn_down,
    input  adj_en, adj_up, adj_down, mode
  );
endinterface
`default_nettype wire

// File: rtl/clock_adjust_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_adjust_ctrl
// Brief    : Synchronises and debounces mode/up/down buttons, cycles the
//            field-select mode, emits single-cycle step pulses with
//            hold-to-repeat, and falls back to RUN after inactivity.
// Revision : 1.0 - initial release
// ============================================================================
module clock_adjust_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned REPEAT_DLY   = 25000000,
  parameter int unsigned REPEAT_PER   = 5000000,
  parameter int unsigned TIMEOUT_CYC  = 500000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  clock_adjust_ctrl_if.master  bus
);

  localparam logic [31:0] c_DEB_LAST = 32'(DEBOUNCE_CYC - 1);
  localparam logic [31:0] c_DLY_LAST = 32'(REPEAT_DLY - 1);
  localparam logic [31:0] c_PER_LAST = 32'(REPEAT_PER - 1);
  localparam logic [31:0] c_TMO_LAST = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_RUN  = 3'd0,
    S_SEC  = 3'd1,
    S_MIN  = 3'd2,
    S_HOUR = 3'd3,
    S_DAY  = 3'd4,
    S_MON  = 3'd5,
    S_YEAR = 3'd6
  } state_t;

  // Button index: 0 mode, 1 up, 2 down
  logic [2:0] w_raw;
  logic [2:0] w_stable;
  logic [2:0] w_press;

  assign w_raw = {bus.btn_down, bus.btn_up, bus.btn_mode};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic [1:0]  r_sync;
      logic [31:0] r_cnt;
      logic        r_stable;
      logic        r_stable_d;

      // Two-flop synchroniser followed by a consecutive-cycle debounce counter
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync     <= 2'b00;
          r_cnt      <= '0;
          r_stable   <= 1'b0;
          r_stable_d <= 1'b0;
        end else begin
          r_sync     <= {r_sync[0], w_raw[gi]};
          r_stable_d <= r_stable;
          if (r_sync[1] == r_stable) begin
            r_cnt <= '0;
          end else if (r_cnt == c_DEB_LAST) begin
            r_stable <= r_sync[1];
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
      end

      assign w_stable[gi] = r_stable;
      assign w_press[gi]  = r_stable & ~r_stable_d;
    end
  endgenerate

  state_t      r_state, w_state_next;
  logic [5:0]  r_adj_en, w_en_next;
  logic        r_adj_up, r_adj_down, w_pulse_up, w_pulse_down;
  logic        r_arm_up, r_arm_down, w_arm_up, w_arm_down;
  logic        r_phase, w_phase;
  logic [31:0] r_rep_cnt, w_rep_cnt;
  logic [31:0] r_idle_cnt, w_idle_cnt;
  logic        w_activity, w_timeout, w_step_ok, w_up_new, w_down_new, w_hold_ok;
  logic [31:0] w_rep_last;

  // State, idle/repeat counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_adj_en   <= 6'd0;
      r_adj_up   <= 1'b0;
      r_adj_down <= 1'b0;
      r_arm_up   <= 1'b0;
      r_arm_down <= 1'b0;
      r_phase    <= 1'b0;
      r_rep_cnt  <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_adj_en   <= w_en_next;
      r_adj_up   <= w_pulse_up;
      r_adj_down <= w_pulse_down;
      r_arm_up   <= w_arm_up;
      r_arm_down <= w_arm_down;
      r_phase    <= w_phase;
      r_rep_cnt  <= w_rep_cnt;
      r_idle_cnt <= w_idle_cnt;
    end
  end

  // Next mode, timeout, step pulse and auto-repeat decisions
  always_comb begin
    w_state_next = r_state;
    w_pulse_up   = 1'b0;
    w_pulse_down = 1'b0;
    w_arm_up     = r_arm_up;
    w_arm_down   = r_arm_down;
    w_phase      = r_phase;
    w_rep_cnt    = r_rep_cnt;
    w_idle_cnt   = r_idle_cnt;
    w_hold_ok    = 1'b0;

    w_activity = (|w_press) | (|w_stable);
    w_timeout  = (r_state != S_RUN) && !w_activity && (r_idle_cnt == c_TMO_LAST);

    // Mode press beats both a step and the timeout
    if (w_press[0]) begin
      w_state_next = (r_state == S_YEAR) ? S_RUN : state_t'(r_state + 3'd1);
    end else if (w_timeout) begin
      w_state_next = S_RUN;
    end

    if (r_state == S_RUN || w_activity || w_timeout) begin
      w_idle_cnt = '0;
    end else begin
      w_idle_cnt = r_idle_cnt + 32'd1;
    end

    // A step only counts while the other step button is released
    w_step_ok  = (r_state != S_RUN) && !w_press[0] && !w_timeout;
    w_up_new   = w_step_ok && w_press[1] && !w_stable[2];
    w_down_new = w_step_ok && w_press[2] && !w_stable[1];
    w_rep_last = r_phase ? c_PER_LAST : c_DLY_LAST;

    if (w_up_new || w_down_new) begin
      w_pulse_up   = w_up_new;
      w_pulse_down = w_down_new;
      w_arm_up     = w_up_new;
      w_arm_down   = w_down_new;
      w_phase      = 1'b0;
      w_rep_cnt    = '0;
    end else if (r_arm_up || r_arm_down) begin
      w_hold_ok = r_arm_up ? (w_stable[1] && !w_stable[2])
                           : (w_stable[2] && !w_stable[1]);
      if (!w_step_ok || !w_hold_ok) begin
        w_arm_up   = 1'b0;
        w_arm_down = 1'b0;
        w_phase    = 1'b0;
        w_rep_cnt  = '0;
      end else if (r_rep_cnt == w_rep_last) begin
        w_pulse_up   = r_arm_up;
        w_pulse_down = r_arm_down;
        w_phase      = 1'b1;
        w_rep_cnt    = '0;
      end else begin
        w_rep_cnt = r_rep_cnt + 32'd1;
      end
    end

    w_en_next = (w_state_next == S_RUN) ? 6'd0
                                        : (6'd1 << (w_state_next - 3'd1));
  end

  assign bus.mode     = r_state;
  assign bus.adj_en   = r_adj_en;
  assign bus.adj_up   = r_adj_up;
  assign bus.adj_down = r_adj_down;

endmodule
`default_nettype wire

// File: tb/tb_clock_adjust_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_adjust_ctrl
// Brief    : Directed self-checking bench for clock_adjust_ctrl with short
//            debounce/repeat/timeout parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_adjust_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  clock_adjust_ctrl_if bus();

  clock_adjust_ctrl #(
    .DEBOUNCE_CYC(4),
    .REPEAT_DLY  (20),
    .REPEAT_PER  (5),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Clean mode press: new mode registered 7 edges after raw rise
  task automatic press_mode();
    bus.btn_mode = 1'b1;
    step(7);
    bus.btn_mode = 1'b0;
    step(8);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    step(3);
    check("rst_mode", 32'(bus.mode), 0);
    check("rst_en",   32'(bus.adj_en), 0);
    check("rst_up",   32'(bus.adj_up), 0);
    check("rst_down", 32'(bus.adj_down), 0);
    rst_n = 1'b1;
    step(2);

    // 1: glitch is rejected, clean press enters SEC at edge 7
    bus.btn_mode = 1'b1;
    step(2);
    bus.btn_mode = 1'b0;
    step(12);
    check("glitch_mode", 32'(bus.mode), 0);
    check("glitch_en",   32'(bus.adj_en), 0);
    bus.btn_mode = 1'b1;
    step(6);
    check("press_en_e6", 32'(bus.adj_en), 0);
    step(1);
    check("press_en_e7",   32'(bus.adj_en), 32'h01);
    check("press_mode_e7", 32'(bus.mode), 1);
    bus.btn_mode = 1'b0;
    step(8);

    // 2: remaining six presses walk MIN..YEAR then back to RUN
    press_mode(); check("cyc_en_min",  32'(bus.adj_en), 32'h02); check("cyc_mode_min",  32'(bus.mode), 2);
    press_mode(); check("cyc_en_hour", 32'(bus.adj_en), 32'h04); check("cyc_mode_hour", 32'(bus.mode), 3);
    press_mode(); check("cyc_en_day",  32'(bus.adj_en), 32'h08); check("cyc_mode_day",  32'(bus.mode), 4);
    press_mode(); check("cyc_en_mon",  32'(bus.adj_en), 32'h10); check("cyc_mode_mon",  32'(bus.mode), 5);
    press_mode(); check("cyc_en_year", 32'(bus.adj_en), 32'h20); check("cyc_mode_year", 32'(bus.mode), 6);
    press_mode(); check("cyc_en_run",  32'(bus.adj_en), 32'h00); check("cyc_mode_run",  32'(bus.mode), 0);

    // 3: MIN, hold up -> pulses at 7, 27, 32, 37, 42, 47 (52 trails the release)
    press_mode();
    press_mode();
    check("rep_en_min", 32'(bus.adj_en), 32'h02);
    bus.btn_up = 1'b1;
    step(7);
    check("rep_first_up",   32'(bus.adj_up), 1);
    check("rep_first_down", 32'(bus.adj_down), 0);
    for (int k = 8; k <= 60; k++) begin
      step(1);
      check("rep_up", 32'(bus.adj_up),
            (k == 27 || k == 32 || k == 37 || k == 42 || k == 47 || k == 52) ? 1 : 0);
      check("rep_down", 32'(bus.adj_down), 0);
      if (k == 47) bus.btn_up = 1'b0;
    end
    check("rep_en_after", 32'(bus.adj_en), 32'h02);

    // 4: HOUR, up then down while up held -> only the first up pulse
    press_mode();
    check("both_en_hour", 32'(bus.adj_en), 32'h04);
    bus.btn_up = 1'b1;
    step(7);
    check("both_first_up", 32'(bus.adj_up), 1);
    for (int k = 8; k <= 60; k++) begin
      step(1);
      check("both_pulses", {30'd0, bus.adj_up, bus.adj_down}, 0);
      if (k == 10) bus.btn_down = 1'b1;
      if (k == 30) bus.btn_down = 1'b0;
    end
    bus.btn_up = 1'b0;
    step(10);

    // 5: DAY idle -> RUN exactly 100 cycles after the mode button settles
    press_mode();
    check("tmo_en_day", 32'(bus.adj_en), 32'h08);
    step(97);
    check("tmo_mode_e112", 32'(bus.mode), 4);
    step(1);
    check("tmo_mode_e113", 32'(bus.mode), 0);
    check("tmo_en_e113",   32'(bus.adj_en), 0);

    // RUN ignores up
    bus.btn_up = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step(1);
      check("run_up_ignored", {30'd0, bus.adj_up, bus.adj_down}, 0);
    end
    bus.btn_up = 1'b0;
    step(10);
    check("run_mode", 32'(bus.mode), 0);

    // Late press restarts the idle count
    press_mode();
    press_mode();
    press_mode();
    press_mode();
    check("rst_cnt_en_day", 32'(bus.adj_en), 32'h08);
    step(89);
    bus.btn_up = 1'b1;
    step(7);
    check("rst_cnt_up", 32'(bus.adj_up), 1);
    bus.btn_up = 1'b0;
    step(2);
    check("rst_cnt_mode_e113", 32'(bus.mode), 4);
    step(103);
    check("rst_cnt_mode_e216", 32'(bus.mode), 4);
    step(1);
    check("rst_cnt_mode_e217", 32'(bus.mode), 0);

    // 6: reset during YEAR auto-repeat
    for (int i = 0; i < 6; i++) press_mode();
    check("ar_en_year", 32'(bus.adj_en), 32'h20);
    bus.btn_up = 1'b1;
    step(7);
    check("ar_first_up", 32'(bus.adj_up), 1);
    step(20);
    check("ar_repeat_up", 32'(bus.adj_up), 1);
    step(2);
    rst_n = 1'b0;
    #1;
    check("ar_rst_en",   32'(bus.adj_en), 0);
    check("ar_rst_up",   32'(bus.adj_up), 0);
    check("ar_rst_mode", 32'(bus.mode), 0);
    bus.btn_up = 1'b0;
    step(3);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step(1);
      check("ar_post_up", 32'(bus.adj_up), 0);
      check("ar_post_en", 32'(bus.adj_en), 0);
    end
    press_mode();
    check("ar_new_mode", 32'(bus.mode), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
